// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder: valid/ready on the
// operand side (a, b, cin, sub) and on the result side (s, cout, ovf).
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per cycle, LSB chunk first.
// Define SEQ_CHUNK_ADDER_OVF_EN to build signed-overflow detection (ovf tied 0 otherwise).
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_chunk_adder_if.slave  bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, out_valid_q;

  logic [CHUNK-1:0] a_chk_s;
  logic [CHUNK-1:0] b_chk_s;
  logic [CHUNK:0]   sum_s;
  logic             ovf_s;
  logic             last_s;

  // Chunk datapath: one CHUNK-bit slice of the ripple addition per cycle.
  always_comb begin
    a_chk_s = a_q[int'(k_q)*CHUNK +: CHUNK];
    b_chk_s = b_q[int'(k_q)*CHUNK +: CHUNK];
    sum_s   = {1'b0, a_chk_s} + {1'b0, b_chk_s} + (CHUNK+1)'(carry_q);
    last_s  = (k_q == KW'(N - 1));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: c = a ^ b ^ s.
    ovf_s   = (a_chk_s[CHUNK-1] ^ b_chk_s[CHUNK-1] ^ sum_s[CHUNK-1]) ^ sum_s[CHUNK];
`else
    ovf_s   = 1'b0;
`endif
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub ? 1'b1 : bus.cin;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[int'(k_q)*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
        carry_d = sum_s[CHUNK];
        if (last_s) begin
          cout_d  = sum_s[CHUNK];
          ovf_d   = ovf_s;
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake flags are registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (CHUNK=4 and CHUNK=16 instances).
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(16)) bus4 ();
  seq_chunk_adder_if #(.WIDTH(16)) bus16 ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  task automatic start4(input logic [15:0] a_v, input logic [15:0] b_v, input logic cin_v, input logic sub_v);
    @(negedge clk);
    bus4.a = a_v; bus4.b = b_v; bus4.cin = cin_v; bus4.sub = sub_v; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume4();
    @(negedge clk);
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus4.in_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus4.in_ready); end
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus4.out_valid); end
    n_cmp++; if (bus4.s !== 16'h0000)     begin n_bad++; $display("FAIL rst_s: got %h want 0000", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b0)      begin n_bad++; $display("FAIL rst_cout: got %b want 0", bus4.cout); end
    n_cmp++; if (bus4.ovf !== 1'b0)       begin n_bad++; $display("FAIL rst_ovf: got %b want 0", bus4.ovf); end
    n_cmp++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready16: got %b want 1", bus16.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_basic();
    int lat;
    start4(16'h1234, 16'h1111, 1'b0, 1'b0);
    n_cmp++; if (bus4.in_ready !== 1'b0) begin n_bad++; $display("FAIL add_run_in_ready: got %b want 0", bus4.in_ready); end
    wait4(lat);
    n_cmp++; if (lat != 4)             begin n_bad++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_cmp++; if (bus4.s !== 16'h2345)  begin n_bad++; $display("FAIL add_s: got %h want 2345", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b0)   begin n_bad++; $display("FAIL add_cout: got %b want 0", bus4.cout); end
    n_cmp++; if (bus4.ovf !== 1'b0)    begin n_bad++; $display("FAIL add_ovf: got %b want 0", bus4.ovf); end
    consume4();
    n_cmp++; if (bus4.in_ready !== 1'b1)  begin n_bad++; $display("FAIL add_ready_after: got %b want 1", bus4.in_ready); end
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_valid_after: got %b want 0", bus4.out_valid); end
  endtask

  task automatic test_carry();
    int lat;
    start4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait4(lat);
    n_cmp++; if (bus4.s !== 16'h0000) begin n_bad++; $display("FAIL carry1_s: got %h want 0000", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b1)  begin n_bad++; $display("FAIL carry1_cout: got %b want 1", bus4.cout); end
    n_cmp++; if (bus4.ovf !== 1'b0)   begin n_bad++; $display("FAIL carry1_ovf: got %b want 0", bus4.ovf); end
    consume4();
    start4(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    wait4(lat);
    n_cmp++; if (bus4.s !== 16'h0000) begin n_bad++; $display("FAIL carry2_s: got %h want 0000", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b1)  begin n_bad++; $display("FAIL carry2_cout: got %b want 1", bus4.cout); end
    n_cmp++; if (bus4.ovf !== 1'b0)   begin n_bad++; $display("FAIL carry2_ovf: got %b want 0", bus4.ovf); end
    consume4();
  endtask

  task automatic test_sub();
    int lat;
    start4(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait4(lat);
    n_cmp++; if (bus4.s !== 16'hFFFE) begin n_bad++; $display("FAIL sub1_s: got %h want fffe", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b0)  begin n_bad++; $display("FAIL sub1_cout: got %b want 0", bus4.cout); end
    n_cmp++; if (bus4.ovf !== 1'b0)   begin n_bad++; $display("FAIL sub1_ovf: got %b want 0", bus4.ovf); end
    consume4();
    start4(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait4(lat);
    n_cmp++; if (bus4.s !== 16'h0002) begin n_bad++; $display("FAIL sub2_s: got %h want 0002", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b1)  begin n_bad++; $display("FAIL sub2_cout: got %b want 1", bus4.cout); end
    n_cmp++; if (bus4.ovf !== 1'b0)   begin n_bad++; $display("FAIL sub2_ovf: got %b want 0", bus4.ovf); end
    consume4();
  endtask

  task automatic test_ovf();
    int lat;
    start4(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait4(lat);
    n_cmp++; if (bus4.s !== 16'h8000) begin n_bad++; $display("FAIL ovf_s: got %h want 8000", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b0)  begin n_bad++; $display("FAIL ovf_cout: got %b want 0", bus4.cout); end
    n_cmp++; if (bus4.ovf !== OVF_EN) begin n_bad++; $display("FAIL ovf_flag: got %b want %b", bus4.ovf, OVF_EN); end
    consume4();
  endtask

  task automatic test_backpressure();
    int lat;
    start4(16'h1234, 16'h1111, 1'b0, 1'b0);
    bus4.a = 16'hAAAA; bus4.b = 16'h5555; bus4.cin = 1'b1; bus4.sub = 1'b1; bus4.in_valid = 1'b1;
    wait4(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus4.s !== 16'h2345)     begin n_bad++; $display("FAIL bp_s[%0d]: got %h want 2345", i, bus4.s); end
      n_cmp++; if (bus4.cout !== 1'b0)      begin n_bad++; $display("FAIL bp_cout[%0d]: got %b want 0", i, bus4.cout); end
      n_cmp++; if (bus4.ovf !== 1'b0)       begin n_bad++; $display("FAIL bp_ovf[%0d]: got %b want 0", i, bus4.ovf); end
      n_cmp++; if (bus4.in_ready !== 1'b0)  begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus4.in_ready); end
      n_cmp++; if (bus4.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus4.out_valid); end
    end
    bus4.in_valid = 1'b0;
    consume4();
    n_cmp++; if (bus4.in_ready !== 1'b1)  begin n_bad++; $display("FAIL bp_ready_after: got %b want 1", bus4.in_ready); end
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_after: got %b want 0", bus4.out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start4(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid: got %b want 0", bus4.out_valid); end
    n_cmp++; if (bus4.s !== 16'h0000)     begin n_bad++; $display("FAIL mrst_s: got %h want 0000", bus4.s); end
    n_cmp++; if (bus4.in_ready !== 1'b1)  begin n_bad++; $display("FAIL mrst_in_ready: got %b want 1", bus4.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (bus4.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_no_result: got %b want 0", bus4.out_valid); end
    start4(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait4(lat);
    n_cmp++; if (lat != 4)             begin n_bad++; $display("FAIL mrst_latency: got %0d want 4", lat); end
    n_cmp++; if (bus4.s !== 16'h0100)  begin n_bad++; $display("FAIL mrst_s_after: got %h want 0100", bus4.s); end
    n_cmp++; if (bus4.cout !== 1'b0)   begin n_bad++; $display("FAIL mrst_cout_after: got %b want 0", bus4.cout); end
    consume4();
  endtask

  task automatic test_n1();
    int lat;
    @(negedge clk);
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat != 1)             begin n_bad++; $display("FAIL n1_latency: got %0d want 1", lat); end
    n_cmp++; if (bus16.s !== 16'h2345) begin n_bad++; $display("FAIL n1_s: got %h want 2345", bus16.s); end
    n_cmp++; if (bus16.cout !== 1'b0)  begin n_bad++; $display("FAIL n1_cout: got %b want 0", bus16.cout); end
    n_cmp++; if (bus16.ovf !== 1'b0)   begin n_bad++; $display("FAIL n1_ovf: got %b want 0", bus16.ovf); end
    @(negedge clk);
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    n_cmp++; if (bus16.in_ready !== 1'b1) begin n_bad++; $display("FAIL n1_ready_after: got %b want 1", bus16.in_ready); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry();
    test_sub();
    test_ovf();
    test_backpressure();
    test_reset_mid_run();
    test_n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
